// File: rtl/calc1_port_seq_if.sv
// Request/response and calc1-facing signals of the calc1 port sequencer.
// master: the sequencer itself; slave: the upstream/downstream/calc1 side.
interface calc1_port_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [0:3]  req_cmd;
    logic [0:31] req_op1;
    logic [0:31] req_op2;
    logic [0:3]  cmd_out;
    logic [0:31] data_out;
    logic [0:1]  resp_in;
    logic [0:31] data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_resp;
    logic [0:31] rsp_data;

    modport master (
        input  req_valid, req_cmd, req_op1, req_op2, resp_in, data_in, rsp_ready,
        output req_ready, cmd_out, data_out, rsp_valid, rsp_resp, rsp_data
    );

    modport slave (
        output req_valid, req_cmd, req_op1, req_op2, resp_in, data_in, rsp_ready,
        input  req_ready, cmd_out, data_out, rsp_valid, rsp_resp, rsp_data
    );
endinterface

// File: rtl/calc1_port_seq.sv
// Sequences one request through a calc1 port (cmd+op1, op2, wait) and holds the result.
// Optional macro CALC1_SEQ_CMD_CHECK_EN: reject commands outside {1,2,5,6} locally.
module calc1_port_seq #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             c_clk,
    input  logic             reset,
    calc1_port_seq_if.master bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_OP1  = 3'd1,
        SEND_OP2  = 3'd2,
        WAIT_RESP = 3'd3,
        HOLD      = 3'd4
    } state_e;

    // Timeout fires on the WAIT_RESP cycle where the count would reach TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [0:3]  cmd_q, cmd_d;
    logic [0:31] op1_q, op1_d;
    logic [0:31] op2_q, op2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [0:1]  resp_q, resp_d;
    logic [0:31] data_q, data_d;

    logic        req_ready_c;
    logic        rsp_valid_c;
    logic [0:3]  cmd_out_c;
    logic [0:31] data_out_c;
    logic        cmd_ok;

`ifdef CALC1_SEQ_CMD_CHECK_EN
    assign cmd_ok = (bus.req_cmd == 4'd1) || (bus.req_cmd == 4'd2) ||
                    (bus.req_cmd == 4'd5) || (bus.req_cmd == 4'd6);
`else
    assign cmd_ok = 1'b1;
`endif

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        data_d      = data_q;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        cmd_out_c   = '0;
        data_out_c  = '0;

        case (state_q)
            IDLE: begin
                // Reset is synchronous, so keep ready low while it is held.
                req_ready_c = !reset;
                if (bus.req_valid && req_ready_c) begin
                    cmd_d = bus.req_cmd;
                    op1_d = bus.req_op1;
                    op2_d = bus.req_op2;
                    if (cmd_ok) begin
                        state_d = SEND_OP1;
                    end else begin
                        resp_d  = 2'd2;
                        data_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            SEND_OP1: begin
                cmd_out_c  = cmd_q;
                data_out_c = op1_q;
                state_d    = SEND_OP2;
            end
            SEND_OP2: begin
                data_out_c = op2_q;
                cnt_d      = '0;
                state_d    = WAIT_RESP;
            end
            WAIT_RESP: begin
                // A real response beats a timeout landing on the same cycle.
                if (bus.resp_in != 2'd0) begin
                    resp_d  = bus.resp_in;
                    data_d  = bus.data_in;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q + 8'd1;
                    resp_d  = 2'd3;
                    data_d  = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.cmd_out   = cmd_out_c;
    assign bus.data_out  = data_out_c;
    assign bus.rsp_resp  = resp_q;
    assign bus.rsp_data  = data_q;
endmodule

// File: tb/tb_calc1_port_seq.sv
// Directed bench for calc1_port_seq with a small behavioural calc1 port model.
module tb_calc1_port_seq;
    logic c_clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    calc1_port_seq_if bus();

    calc1_port_seq #(.TIMEOUT(64)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    // calc1 model: grabs cmd/op1 then op2, answers m_delay cycles into the wait.
    logic [1:0]  m_phase;
    logic [3:0]  m_cmd;
    logic [31:0] m_op1, m_op2;
    int          m_wait;
    int          m_delay = 0;
    bit          m_mute = 1'b0;
    logic [33:0] m_res;
    logic        m_act;

    function automatic logic [33:0] calc1_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                calc1_model = s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            end
            4'd2: calc1_model = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5: calc1_model = {2'd1, a << b[4:0]};
            4'd6: calc1_model = {2'd1, a >> b[4:0]};
            default: calc1_model = {2'd2, 32'd0};
        endcase
    endfunction

    always @(posedge c_clk) begin
        if (reset) begin
            m_phase <= 2'd0;
        end else begin
            case (m_phase)
                2'd0: if (bus.cmd_out != 4'd0) begin
                    m_cmd   <= bus.cmd_out;
                    m_op1   <= bus.data_out;
                    m_phase <= 2'd1;
                end
                2'd1: begin
                    m_op2   <= bus.data_out;
                    m_wait  <= 0;
                    m_phase <= 2'd2;
                end
                2'd2: if (m_mute || m_wait == m_delay) m_phase <= 2'd0;
                      else m_wait <= m_wait + 1;
                default: m_phase <= 2'd0;
            endcase
        end
    end

    assign m_res       = calc1_model(m_cmd, m_op1, m_op2);
    assign m_act       = (m_phase == 2'd2) && !m_mute && (m_wait == m_delay);
    assign bus.resp_in = m_act ? m_res[33:32] : 2'd0;
    assign bus.data_in = m_act ? m_res[31:0] : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        check("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_op1   = a;
        bus.req_op2   = b;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic take(input string tag);
        bus.rsp_ready = 1'b1;
        check({tag, "_ready_in_hold"}, 32'(bus.req_ready), 32'd0);
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, "_valid_after_take"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_ready_after_take"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int n;
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cmd_out",   32'(bus.cmd_out), 32'd0);
        check("rst_data_out",  bus.data_out, 32'd0);
        check("rst_rsp_resp",  32'(bus.rsp_resp), 32'd0);
        check("rst_rsp_data",  bus.rsp_data, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", 32'(bus.req_ready), 32'd1);

        // Add without overflow, immediate calc1 answer.
        m_delay = 0;
        send(4'd1, 32'h0000_0001, 32'h01FF_FFFF);
        check("add_op1_cmd",  32'(bus.cmd_out), 32'd1);
        check("add_op1_data", bus.data_out, 32'h0000_0001);
        check("add_op1_busy", 32'(bus.req_ready), 32'd0);
        tick();
        check("add_op2_cmd",  32'(bus.cmd_out), 32'd0);
        check("add_op2_data", bus.data_out, 32'h01FF_FFFF);
        tick();
        check("add_wait_cmd",   32'(bus.cmd_out), 32'd0);
        check("add_wait_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("add_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_resp",  32'(bus.rsp_resp), 32'd1);
        check("add_data",  bus.rsp_data, 32'h0200_0000);
        check("add_hold_data_out", bus.data_out, 32'd0);
        take("add");

        // Add overflow reported by calc1, two cycles late.
        m_delay = 2;
        send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_valid(20, n);
        check("ovf_latency", 32'(n), 32'd5);
        check("ovf_resp", 32'(bus.rsp_resp), 32'd2);
        check("ovf_data", bus.rsp_data, 32'd0);
        take("ovf");

        // No response at all: timeout after 64 wait cycles.
        m_mute = 1'b1;
        send(4'd1, 32'd7, 32'd8);
        wait_valid(100, n);
        check("to_latency", 32'(n), 32'd66);
        check("to_resp", 32'(bus.rsp_resp), 32'd3);
        check("to_data", bus.rsp_data, 32'd0);
        take("to");
        m_mute = 1'b0;

        // Response on the very cycle the timeout would fire.
        m_delay = 63;
        send(4'd5, 32'd1, 32'd4);
        wait_valid(100, n);
        check("race_latency", 32'(n), 32'd66);
        check("race_resp", 32'(bus.rsp_resp), 32'd1);
        check("race_data", bus.rsp_data, 32'd16);
        take("race");

        // Downstream stall for 10 cycles.
        m_delay = 1;
        send(4'd2, 32'd10, 32'd3);
        wait_valid(20, n);
        check("stall_latency", 32'(n), 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_data",  bus.rsp_data, 32'd7);
            check("stall_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        check("stall_resp", 32'(bus.rsp_resp), 32'd1);
        take("stall");

        // Shift right.
        m_delay = 0;
        send(4'd6, 32'h8000_0000, 32'd31);
        wait_valid(20, n);
        check("shr_latency", 32'(n), 32'd3);
        check("shr_data", bus.rsp_data, 32'd1);
        take("shr");

        // Unsupported command 3.
`ifdef CALC1_SEQ_CMD_CHECK_EN
        send(4'd3, 32'd1, 32'd2);
        check("bad_valid", 32'(bus.rsp_valid), 32'd1);
        check("bad_cmd_out", 32'(bus.cmd_out), 32'd0);
        check("bad_resp", 32'(bus.rsp_resp), 32'd2);
        check("bad_data", bus.rsp_data, 32'd0);
        take("bad");
`else
        send(4'd3, 32'd1, 32'd2);
        check("bad_cmd_out", 32'(bus.cmd_out), 32'd3);
        tick();
        check("bad_cmd_out_once", 32'(bus.cmd_out), 32'd0);
        wait_valid(20, n);
        check("bad_latency", 32'(n), 32'd2);
        check("bad_resp", 32'(bus.rsp_resp), 32'd2);
        check("bad_data", bus.rsp_data, 32'd0);
        take("bad");
`endif

        // Reset in SEND_OP2 abandons the request.
        send(4'd1, 32'd100, 32'd200);
        tick();
        check("rst2_in_op2", bus.data_out, 32'd200);
        reset = 1'b1;
        tick();
        check("rst2_cmd_out",  32'(bus.cmd_out), 32'd0);
        check("rst2_data_out", bus.data_out, 32'd0);
        check("rst2_valid",    32'(bus.rsp_valid), 32'd0);
        check("rst2_ready",    32'(bus.req_ready), 32'd0);
        check("rst2_resp",     32'(bus.rsp_resp), 32'd0);
        reset = 1'b0;
        #1;
        send(4'd1, 32'd2, 32'd3);
        wait_valid(20, n);
        check("rst2_latency", 32'(n), 32'd3);
        check("rst2_add_resp", 32'(bus.rsp_resp), 32'd1);
        check("rst2_add_data", bus.rsp_data, 32'd5);
        take("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/calc1_port_seq.md
CALC1_PORT_SEQ -- requirements
Module: calc1_port_seq

Interface
REQ-001 SHALL have parameter: TIMEOUT, 64, max c_clk cycles spent in WAIT_RESP before a timeout response is generated (range 4..255).
REQ-002 SHALL have port: c_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  upstream request present.
REQ-005 SHALL have port: req_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port: req_cmd  input  [0:3]  calc1 command code.
REQ-007 SHALL have port: req_op1  input  [0:31]  first operand.
REQ-008 SHALL have port: req_op2  input  [0:31]  second operand.
REQ-009 SHALL have port: cmd_out  output  [0:3]  drives calc1 reqN_cmd_in.
REQ-010 SHALL have port: data_out  output  [0:31]  drives calc1 reqN_data_in.
REQ-011 SHALL have port: resp_in  input  [0:1]  from calc1 out_respN.
REQ-012 SHALL have port: data_in  input  [0:31]  from calc1 out_dataN.
REQ-013 SHALL have port: rsp_valid  output  1  result held for downstream.
REQ-014 SHALL have port: rsp_ready  input  1  downstream takes result.
REQ-015 SHALL have port: rsp_resp  output  [0:1]  1 success, 2 error/overflow/invalid, 3 timeout.
REQ-016 SHALL have port: rsp_data  output  [0:31]  result data.

Function
REQ-017 SHALL implement FSM states IDLE, SEND_OP1, SEND_OP2, WAIT_RESP, HOLD.
REQ-018 SHALL assert req_ready only in IDLE; handshake req_valid&req_ready latches cmd/op1/op2 and moves to SEND_OP1.
REQ-019 SHALL drive cmd_out=latched cmd, data_out=op1 for exactly one cycle in SEND_OP1, then go to SEND_OP2.
REQ-020 SHALL drive cmd_out=0, data_out=op2 for exactly one cycle in SEND_OP2, then go to WAIT_RESP with timeout counter cleared.
REQ-021 SHALL drive cmd_out=0, data_out=0 in IDLE, WAIT_RESP and HOLD.
REQ-022 SHALL, in WAIT_RESP, on first cycle resp_in!=0 capture resp_in into rsp_resp and data_in into rsp_data, go to HOLD.
REQ-023 SHALL increment an 8-bit counter each WAIT_RESP cycle with resp_in==0; when it reaches TIMEOUT, go to HOLD with rsp_resp=3, rsp_data=0.
REQ-024 SHALL, if resp_in!=0 on the same cycle the counter reaches TIMEOUT, take the real response (response wins).
REQ-025 SHALL assert rsp_valid only in HOLD, holding rsp_resp/rsp_data stable until rsp_valid&rsp_ready, then return to IDLE.
REQ-026 SHALL not bypass: req_ready rises the cycle after HOLD exits, never in the same cycle.
REQ-027 SHALL ignore resp_in in IDLE, SEND_OP1, SEND_OP2 and HOLD.
REQ-028 SHALL give request-accept to rsp_valid latency of 3 + N cycles, N = calc1 response delay after SEND_OP2.

Reset
REQ-029 SHALL on reset=1 at a rising edge enter IDLE from any state, abandoning any in-flight request.
REQ-030 SHALL reset outputs: req_ready=0 while reset high then 1, cmd_out=0, data_out=0, rsp_valid=0, rsp_resp=0, rsp_data=0, counter=0.

Configuration
REQ-031 SHALL, with CALC1_SEQ_CMD_CHECK_EN defined, treat req_cmd not in {1,2,5,6} as invalid: skip SEND_OP1/SEND_OP2/WAIT_RESP, go IDLE->HOLD with rsp_resp=2, rsp_data=0, cmd_out stays 0.
REQ-032 SHALL, without CALC1_SEQ_CMD_CHECK_EN, forward every req_cmd to calc1 unchanged and report calc1's response.

Verification
REQ-033 SHALL cover: cmd 1, op1 0000_0001h, op2 01FF_FFFFh, calc1 model answers -> rsp_resp=1, rsp_data=0200_0000h; cmd_out=1 for exactly one cycle.
REQ-034 SHALL cover: cmd 1, op1 FFFF_FFFFh, op2 0000_0001h -> rsp_resp=2 passed through from calc1.
REQ-035 SHALL cover: resp_in held 0, TIMEOUT=64 -> rsp_valid rises 64 cycles into WAIT_RESP, rsp_resp=3, rsp_data=0.
REQ-036 SHALL cover: rsp_ready low 10 cycles after result -> rsp_valid/rsp_data stable, req_ready=0 throughout, req_ready=1 one cycle after handshake.
REQ-037 SHALL cover: cmd 3 -> with macro rsp_resp=2 and cmd_out never nonzero; without macro cmd_out=3 for one cycle.
REQ-038 SHALL cover: reset asserted in SEND_OP2 -> next cycle cmd_out=0, data_out=0, rsp_valid=0, subsequent add 2+3 returns 5, resp 1.
